// File: rtl/cdc_ctrl_pkg.sv
// Shared types and constants for the source-side CDC handshake controller.
package cdc_ctrl_pkg;

  // Handshake phases of the source-side 4-phase req/ack sequence.
  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_REQ_HI = 2'd1,
    HS_REQ_LO = 2'd2
  } hs_state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Width of a counter that can reach 'cycles'; never below 1 bit so a
  // disabled timeout (cycles == 0) still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_2dff.sv
// Two-flop level synchronizer for a single asynchronous control bit.
// The output follows the input two destination-clock edges later.
module sync_2dff #(
  parameter bit SYNTHESIS = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw level into the two-stage chain.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchronizer registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

  // Simulation model: a level crossing the boundary must be held for at
  // least two samples, otherwise it could be lost in a metastable window.
  generate
    if (SYNTHESIS == 1'b0) begin : g_sim_model
      a_level_held : assert property (
        @(posedge clk_i) disable iff (!rstn_i) $changed(d_i) |=> $stable(d_i)
      );
    end
  endgenerate

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// Source-domain controller for a 4-phase req/ack CDC handshake.
// Handshake: a word is taken when valid_i & ready_o are both high at a clock
// edge; the word is then held on data_o while req_o is raised, req_o drops
// once the synchronized ack is seen high, and the block returns to idle when
// the synchronized ack falls again. Each phase is guarded by a timeout.
module cdc_hs_src_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter bit          SYNTHESIS      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output hs_state_e         dbg_state_o
);

  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  hs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              hi_tmo_q, hi_tmo_d;   // REQ_HI was left by timeout
  logic              ack_s;
  logic              tmo_hit;
  logic [CNT_W-1:0]  cnt_inc;

  sync_2dff #(
    .SYNTHESIS (SYNTHESIS)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (ack_i),
    .q_o    (ack_s)
  );

  assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, counter and output decode; ack beats timeout in both phases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    data_d   = data_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    hi_tmo_d = hi_tmo_q;
    unique case (state_q)
      HS_IDLE: begin
        if (valid_i && !ack_s) begin
          data_d   = data_i;
          req_d    = 1'b1;
          cnt_d    = '0;
          hi_tmo_d = 1'b0;
          state_d  = HS_REQ_HI;
        end
      end
      HS_REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = HS_REQ_LO;
        end else if (tmo_hit) begin
          req_d    = 1'b0;
          tmo_d    = 1'b1;
          cnt_d    = '0;
          hi_tmo_d = 1'b1;
          state_d  = HS_REQ_LO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HS_REQ_LO: begin
        if (!ack_s) begin
          done_d  = !hi_tmo_q;
          state_d = HS_IDLE;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = HS_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = HS_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= HS_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      hi_tmo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      data_q   <= data_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      hi_tmo_q <= hi_tmo_d;
    end
  end

  assign ready_o     = (state_q == HS_IDLE) && !ack_s;
  assign busy_o      = (state_q != HS_IDLE);
  assign req_o       = req_q;
  assign data_o      = data_q;
  assign done_o      = done_q;
  assign timeout_o   = tmo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Directed bench for the source-side CDC handshake controller.
module tb_cdc_hs_src_ctrl;
  import cdc_ctrl_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMO    = 16;
  localparam int unsigned EW     = DATA_W + 2;
  localparam logic [1:0]  EV_REQ  = 2'd1;
  localparam logic [1:0]  EV_DONE = 2'd2;
  localparam logic [1:0]  EV_TMO  = 2'd3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ack = 1'b0;
  logic              ready_o, req_o, busy_o, done_o, timeout_o;
  logic [DATA_W-1:0] data_o;
  hs_state_e         dbg_state;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic prev_req = 1'b0;

  cdc_hs_src_ctrl #(
    .DATA_W         (DATA_W),
    .SYNTHESIS      (1'b0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .valid_i     (valid),
    .data_i      (data_in),
    .ready_o     (ready_o),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_i       (ack),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required finish within 300us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [DATA_W-1:0] d);
    exp_q.push_back({kind, d});
  endtask

  // Destination model: raise ack after req is seen, drop it after req falls.
  task automatic ack_handshake(input int rise_dly, input int fall_dly,
                               input logic [DATA_W-1:0] exp_data);
    int n;
    n = 0;
    while (!req_o && n < 50) begin tick(); n++; end
    check("hs_req_seen", req_o, 1);
    repeat (rise_dly) tick();
    ack = 1'b1;
    n = 0;
    while (req_o && n < 50) begin
      check("hs_data_hold", data_o, exp_data);
      tick();
      n++;
    end
    check("hs_req_drop", req_o, 0);
    check("hs_data_after_drop", data_o, exp_data);
    repeat (fall_dly) tick();
    ack = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_o && n < 50) begin tick(); n++; end
    check(name, done_o, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon_pop(input logic [1:0] kind, input logic [DATA_W-1:0] d);
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    got = {kind, d};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected: got kind=%0d data=%0h required no event", kind, d);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL sb_event: got kind=%0d data=%0h required kind=%0d data=%0h",
                 kind, d, want[EW-1 -: 2], want[DATA_W-1:0]);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (req_o && !prev_req) mon_pop(EV_REQ, data_o);
    if (done_o)             mon_pop(EV_DONE, data_o);
    if (timeout_o)          mon_pop(EV_TMO, data_o);
    prev_req = req_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset state
    rstn = 1'b0;
    repeat (2) tick();
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_tmo", timeout_o, 0);
    check("rst_state", dbg_state, HS_IDLE);
    rstn = 1'b1;
    tick();
    check("rst_ready", ready_o, 1);

    // 1. Normal transfer with exact latencies (edge 0 = accept)
    valid = 1'b1; data_in = 8'hA5;
    expect_ev(EV_REQ, 8'hA5); expect_ev(EV_DONE, 8'hA5);
    tick();                                    // edge 0
    valid = 1'b0; data_in = 8'h00;
    check("t1_req_up", req_o, 1);
    check("t1_data", data_o, 8'hA5);
    check("t1_ready_busy", ready_o, 0);
    repeat (4) tick();                         // edges 1..4
    ack = 1'b1;                                // sampled at edge 5
    tick(); check("t1_req_e5", req_o, 1);
    tick(); check("t1_req_e6", req_o, 1);
    tick(); check("t1_req_e7", req_o, 0);
    check("t1_data_e7", data_o, 8'hA5);
    check("t1_state_lo", dbg_state, HS_REQ_LO);
    repeat (3) tick();                         // edges 8..10
    ack = 1'b0;                                // sampled at edge 11
    tick();
    tick(); check("t1_done_e12", done_o, 0);
    check("t1_busy_e12", busy_o, 1);
    tick(); check("t1_done_e13", done_o, 1);
    check("t1_busy_e13", busy_o, 0);
    check("t1_ready_e13", ready_o, 1);
    check("t1_tmo_e13", timeout_o, 0);
    tick(); check("t1_done_e14", done_o, 0);
    check("t1_data_e14", data_o, 8'hA5);

    // 2. Back-to-back with valid held
    valid = 1'b1; data_in = 8'h01;
    expect_ev(EV_REQ, 8'h01); expect_ev(EV_DONE, 8'h01);
    expect_ev(EV_REQ, 8'h02); expect_ev(EV_DONE, 8'h02);
    tick();
    check("t2_first_data", data_o, 8'h01);
    data_in = 8'h02;
    ack_handshake(2, 2, 8'h01);
    wait_done("t2_done1");
    check("t2_data_at_done", data_o, 8'h01);
    tick();
    check("t2_second_req", req_o, 1);
    check("t2_second_data", data_o, 8'h02);
    valid = 1'b0;
    ack_handshake(1, 3, 8'h02);
    wait_done("t2_done2");

    // 3. Dead destination: timeout in cycle 16 of REQ_HI
    tick();
    valid = 1'b1; data_in = 8'h3C;
    expect_ev(EV_REQ, 8'h3C); expect_ev(EV_TMO, 8'h3C);
    tick();                                    // edge 0
    valid = 1'b0;
    repeat (15) tick();                        // edges 1..15
    check("t3_req_pre", req_o, 1);
    check("t3_tmo_pre", timeout_o, 0);
    tick();                                    // edge 16
    check("t3_tmo", timeout_o, 1);
    check("t3_req_down", req_o, 0);
    check("t3_done_none", done_o, 0);
    tick();                                    // edge 17
    check("t3_idle_busy", busy_o, 0);
    check("t3_idle_done", done_o, 0);
    check("t3_tmo_pulse", timeout_o, 0);
    check("t3_ready", ready_o, 1);

    // 4. Stuck ack: REQ_LO times out, no accept while ack_s stays high
    valid = 1'b1; data_in = 8'h5A;
    expect_ev(EV_REQ, 8'h5A); expect_ev(EV_TMO, 8'h5A);
    tick();                                    // edge 0
    valid = 1'b0;
    ack = 1'b1;
    n = 0;
    while (!timeout_o && n < 40) begin tick(); n++; end
    check("t4_tmo", timeout_o, 1);
    check("t4_tmo_cycle", n, 19);
    check("t4_req", req_o, 0);
    check("t4_idle", busy_o, 0);
    check("t4_ready_blocked", ready_o, 0);
    valid = 1'b1; data_in = 8'h77;
    expect_ev(EV_REQ, 8'h77); expect_ev(EV_DONE, 8'h77);
    repeat (3) tick();
    check("t4_no_accept", req_o, 0);
    check("t4_still_blocked", ready_o, 0);
    ack = 1'b0;
    tick(); check("t4_ready_a", ready_o, 0);
    tick(); check("t4_ready_a1", ready_o, 1);
    check("t4_req_a1", req_o, 0);
    tick(); check("t4_accept_req", req_o, 1);
    check("t4_accept_data", data_o, 8'h77);
    valid = 1'b0;
    ack_handshake(2, 2, 8'h77);
    wait_done("t4_done");

    // 5. Reset mid-handshake in REQ_HI
    tick();
    valid = 1'b1; data_in = 8'h99;
    expect_ev(EV_REQ, 8'h99);
    tick();
    valid = 1'b0;
    repeat (2) tick();
    check("t5_in_hi", dbg_state, HS_REQ_HI);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t5_req", req_o, 0);
    check("t5_data", data_o, 0);
    check("t5_state", dbg_state, HS_IDLE);
    check("t5_done", done_o, 0);
    check("t5_tmo", timeout_o, 0);
    repeat (20) tick();
    check("t5_ready", ready_o, 1);

    // 6. Race: ack_s rises in the cycle cnt == TMO-1; ack wins
    valid = 1'b1; data_in = 8'hC3;
    expect_ev(EV_REQ, 8'hC3); expect_ev(EV_DONE, 8'hC3);
    tick();                                    // edge 0
    valid = 1'b0;
    repeat (13) tick();                        // edges 1..13
    ack = 1'b1;                                // sampled at edge 14
    tick();
    tick();                                    // edge 15
    check("t6_req_e15", req_o, 1);
    check("t6_state_e15", dbg_state, HS_REQ_HI);
    tick();                                    // edge 16
    check("t6_req_e16", req_o, 0);
    check("t6_no_tmo", timeout_o, 0);
    check("t6_state_lo", dbg_state, HS_REQ_LO);
    repeat (2) tick();
    ack = 1'b0;
    wait_done("t6_done");
    check("t6_done_no_tmo", timeout_o, 0);

    // Drain
    repeat (5) tick();
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
